multicycle_ctrl_p: RTL and testbench
====================================

// Module: multicycle_ctrl_p
// PURPOSE
//  Parametrised multi-cycle control FSM for the register-file datapath.
//  Latches one instruction per run, sequences the IR/A/G/register-enable strobes, drives the bus mux and ALU op, pulses done.
//  Generalised over register count and instruction width; adds per-opcode sequencing, abort and range-check error reporting.
//  Sits between the instruction source and the datapath (register file, A, G, bus mux, ALU).
// PARAMETERS
//  NREGS    8   number of GP registers (2..16)
//  IW       16  instruction width; requires 2*RAW+5 <= IW
//  ALU_W    3   ALU select width (field instruction[ALU_W+1:2])
//  RAW      $clog2(NREGS)    derived (localparam): register-index field width
//  MUX_W    $clog2(NREGS+2)  derived (localparam): bus mux select width
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  run          in   1       level; start/continue instruction
//  instruction  in   IW      sampled only in FETCH
//  done         out  1       1-cycle pulse in WB (or NOP) state
//  busy         out  1       high in any state except IDLE
//  err          out  1       1-cycle pulse: register index >= NREGS
//  en_i         out  1       IR load strobe (FETCH)
//  en_s         out  1       A load strobe
//  en_c         out  1       G load strobe
//  reg_en       out  NREGS   one-hot register write enable
//  mux_sel      out  MUX_W   0..NREGS-1 = Rn, NREGS = G, NREGS+1 = DIN
//  alu_sel      out  ALU_W   ALU operation
// BEHAVIOUR
//  Fields from latched ir: rx=ir[IW-1 -: RAW], ry=ir[IW-1-RAW -: RAW], alu=ir[ALU_W+1:2], op=ir[1:0].
//  op: 00 MV rx<-ry; 10 ALU rx<-rx alu ry; 01 MVI (see CONFIGURATION); 11 NOP.
//  States: IDLE, FETCH, LOAD_A, LOAD_G, WB, FIN.
//  IDLE: run=1 -> FETCH; all outputs 0.
//  FETCH: en_i=1; ir<=instruction. Next state from the decode of instruction (same cycle): MV/MVI -> WB; ALU -> LOAD_A; NOP -> FIN.
//  LOAD_A: en_s=1, mux_sel=rx -> LOAD_G.
//  LOAD_G: en_c=1, mux_sel=ry, alu_sel=alu -> WB.
//  WB: reg_en[rx]=1, done=1, mux_sel = G (ALU) | ry (MV) | DIN (MVI) -> IDLE.
//  FIN: done=1, no writes -> IDLE.
//  Latency, counted in cycles after leaving IDLE: ALU done in cycle 4, MV/MVI in 2, NOP in 2.
//  After returning to IDLE, a new instruction starts on the next edge if run is still 1 (back-to-back).
//  run=0 in any non-IDLE state -> IDLE next edge. No reg_en/done is issued in the abort cycle itself (outputs are state-decoded; WB is never entered).
//  rx or ry >= NREGS (non-power-of-2 NREGS): abort at the FETCH decode. err pulses the cycle after FETCH, in FIN; done also pulses; reg_en stays 0.
//  Outputs are combinational from state and ir; ir and state are the only flops.
//  reset (any time): state=IDLE, ir=0; all outputs 0 immediately.
// CONFIGURATION
//  MULTICYCLE_MVI_EN defined: op 01 = MVI. WB drives mux_sel=NREGS+1 (DIN) and writes rx.
//  Not defined: op 01 is decoded as NOP (FETCH->FIN; done pulses, no writes).
// STRUCTURE
//  ctrl_pkg: opcode localparams, state encoding, field-offset functions, mux code constants (MUX_G, MUX_DIN).
//  Sub-module ctrl_decode: combinational field extraction + range check -> {rx, ry, alu, op, bad_idx}.
// TESTING
//  Reset mid-LOAD_G -> all outputs 0 same cycle; IDLE; next instruction fetches cleanly.
//  ALU R3<-R3 op5 R6 (NREGS=8) -> en_i, en_s(mux_sel=3), en_c(mux_sel=6, alu_sel=5), then reg_en=8'h08 + done with mux_sel=8.
//  MV R1<-R7 with run held high -> WB: reg_en=8'h02, mux_sel=7; next FETCH immediately after IDLE.
//  run dropped in LOAD_A -> IDLE next edge; no reg_en, no done.
//  NREGS=6, rx=7 -> err and done pulse, reg_en=0.
//  op 01 with and without MULTICYCLE_MVI_EN -> WB mux_sel=9, rx written / FIN, no write.

Source files
------------

// File: rtl/multicycle_ctrl_p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_p_pkg
//  Description : Shared constants for the multi-cycle control FSM: opcode
//                codes, state encoding, instruction field-offset helpers and
//                bus-mux code helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_p_pkg;

    // Opcode field ir[1:0]
    localparam logic [1:0] c_OP_MV  = 2'b00;
    localparam logic [1:0] c_OP_MVI = 2'b01;
    localparam logic [1:0] c_OP_ALU = 2'b10;
    localparam logic [1:0] c_OP_NOP = 2'b11;

    // State encoding
    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_FETCH   = 3'd1;
    localparam logic [2:0] c_S_LOAD_A  = 3'd2;
    localparam logic [2:0] c_S_LOAD_G  = 3'd3;
    localparam logic [2:0] c_S_WB      = 3'd4;
    localparam logic [2:0] c_S_FIN     = 3'd5;

    // MSB position of the destination register field (top of the word)
    function automatic int rx_msb(input int iw);
        return iw - 1;
    endfunction

    // MSB position of the source register field (just below rx)
    function automatic int ry_msb(input int iw, input int raw);
        return iw - 1 - raw;
    endfunction

    // Bus-mux code selecting the G register
    function automatic int mux_g(input int nregs);
        return nregs;
    endfunction

    // Bus-mux code selecting the external data input
    function automatic int mux_din(input int nregs);
        return nregs + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_p_decode.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_p_decode
//  Description : Combinational instruction field extraction plus register
//                index range check (only meaningful for non-power-of-2 NREGS).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_p_decode
    import multicycle_ctrl_p_pkg::*;
#(
    parameter  int NREGS = 8,
    parameter  int IW    = 16,
    parameter  int ALU_W = 3,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic [IW-1:0]    i_ir,
    output logic [RAW-1:0]   o_rx,
    output logic [RAW-1:0]   o_ry,
    output logic [ALU_W-1:0] o_alu,
    output logic [1:0]       o_op,
    output logic             o_bad_idx
);

    localparam int c_RX_MSB = rx_msb(IW);
    localparam int c_RY_MSB = ry_msb(IW, RAW);

    assign o_rx  = i_ir[c_RX_MSB -: RAW];
    assign o_ry  = i_ir[c_RY_MSB -: RAW];
    assign o_alu = i_ir[ALU_W+1:2];
    assign o_op  = i_ir[1:0];

    // Bits between the register and ALU fields carry no meaning here
    logic w_unused;
    assign w_unused = ^i_ir;

    generate
        if ((1 << RAW) == NREGS) begin : g_pow2
            // Every encodable index addresses a real register
            assign o_bad_idx = 1'b0;
        end else begin : g_range
            localparam logic [RAW:0] c_NREGS = (RAW+1)'(NREGS);
            assign o_bad_idx = ({1'b0, o_rx} >= c_NREGS) ||
                               ({1'b0, o_ry} >= c_NREGS);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_p.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_p
//  Description : Parametrised multi-cycle control FSM for the register-file
//                datapath. Latches one instruction per run and sequences the
//                IR / A / G / register-enable strobes, bus mux and ALU op.
//                Optional macro MULTICYCLE_MVI_EN: op 01 becomes MVI (write
//                rx from DIN); otherwise op 01 behaves as NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_p
    import multicycle_ctrl_p_pkg::*;
#(
    parameter  int NREGS = 8,
    parameter  int IW    = 16,
    parameter  int ALU_W = 3,
    localparam int RAW   = $clog2(NREGS),
    localparam int MUX_W = $clog2(NREGS + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [IW-1:0]    instruction,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic             en_i,
    output logic             en_s,
    output logic             en_c,
    output logic [NREGS-1:0] reg_en,
    output logic [MUX_W-1:0] mux_sel,
    output logic [ALU_W-1:0] alu_sel
);

`ifdef MULTICYCLE_MVI_EN
    localparam logic c_MVI_EN = 1'b1;
`else
    localparam logic c_MVI_EN = 1'b0;
`endif

    localparam logic [MUX_W-1:0] c_MUX_G   = MUX_W'(mux_g(NREGS));
    localparam logic [MUX_W-1:0] c_MUX_DIN = MUX_W'(mux_din(NREGS));

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next;
    logic [IW-1:0]     r_ir;

    // Decode of the live instruction bus, used only to pick the path out of FETCH
    logic [RAW-1:0]   w_f_rx;
    logic [RAW-1:0]   w_f_ry;
    logic [ALU_W-1:0] w_f_alu;
    logic [1:0]       w_f_op;
    logic             w_f_bad;

    // Decode of the latched instruction, drives the datapath controls
    logic [RAW-1:0]   w_rx;
    logic [RAW-1:0]   w_ry;
    logic [ALU_W-1:0] w_alu;
    logic [1:0]       w_op;
    logic             w_bad;

    multicycle_ctrl_p_decode #(
        .NREGS (NREGS),
        .IW    (IW),
        .ALU_W (ALU_W)
    ) u_dec_fetch (
        .i_ir      (instruction),
        .o_rx      (w_f_rx),
        .o_ry      (w_f_ry),
        .o_alu     (w_f_alu),
        .o_op      (w_f_op),
        .o_bad_idx (w_f_bad)
    );

    multicycle_ctrl_p_decode #(
        .NREGS (NREGS),
        .IW    (IW),
        .ALU_W (ALU_W)
    ) u_dec_ir (
        .i_ir      (r_ir),
        .o_rx      (w_rx),
        .o_ry      (w_ry),
        .o_alu     (w_alu),
        .o_op      (w_op),
        .o_bad_idx (w_bad)
    );

    // Only op and range status of the live bus matter for sequencing
    logic w_unused;
    assign w_unused = ^{w_f_rx, w_f_ry, w_f_alu};

    // One-hot write enable for the destination register
    logic [NREGS-1:0] w_onehot;
    assign w_onehot = NREGS'(1) << w_rx;

    // State register and instruction latch (IR captured while in FETCH)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_S_FETCH) begin
                r_ir <= instruction;
            end
        end
    end

    // Next-state selection; dropping run anywhere outside IDLE aborts
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (run) begin
                    w_next = c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                if (w_f_bad) begin
                    w_next = c_S_FIN;
                end else begin
                    case (w_f_op)
                        c_OP_MV:  w_next = c_S_WB;
                        c_OP_MVI: w_next = c_MVI_EN ? c_S_WB : c_S_FIN;
                        c_OP_ALU: w_next = c_S_LOAD_A;
                        default:  w_next = c_S_FIN;
                    endcase
                end
            end
            c_S_LOAD_A: w_next = c_S_LOAD_G;
            c_S_LOAD_G: w_next = c_S_WB;
            c_S_WB:     w_next = c_S_IDLE;
            c_S_FIN:    w_next = c_S_IDLE;
            default:    w_next = c_S_IDLE;
        endcase
        if (!run && (r_state != c_S_IDLE)) begin
            w_next = c_S_IDLE;
        end
    end

    // Datapath controls decoded purely from state and the latched instruction
    always_comb begin
        done    = 1'b0;
        busy    = (r_state != c_S_IDLE);
        err     = 1'b0;
        en_i    = 1'b0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        reg_en  = '0;
        mux_sel = '0;
        alu_sel = '0;
        case (r_state)
            c_S_FETCH: begin
                en_i = 1'b1;
            end
            c_S_LOAD_A: begin
                en_s    = 1'b1;
                mux_sel = MUX_W'(w_rx);
            end
            c_S_LOAD_G: begin
                en_c    = 1'b1;
                mux_sel = MUX_W'(w_ry);
                alu_sel = w_alu;
            end
            c_S_WB: begin
                reg_en = w_onehot;
                done   = 1'b1;
                if (w_op == c_OP_ALU) begin
                    mux_sel = c_MUX_G;
                end else if (w_op == c_OP_MVI) begin
                    mux_sel = c_MUX_DIN;
                end else begin
                    mux_sel = MUX_W'(w_ry);
                end
            end
            c_S_FIN: begin
                done = 1'b1;
                err  = w_bad;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl_p
//  Description : Bench for multicycle_ctrl_p. Two instances (NREGS=8 and
//                NREGS=6) share clk/reset/run/instruction; a per-instance
//                instruction-level model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_p;

`ifdef MULTICYCLE_MVI_EN
    localparam bit c_MVI = 1'b1;
`else
    localparam bit c_MVI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] instruction = '0;

    logic       done8, busy8, err8, en_i8, en_s8, en_c8;
    logic [7:0] reg_en8;
    logic [3:0] mux8;
    logic [2:0] alu8;

    logic       done6, busy6, err6, en_i6, en_s6, en_c6;
    logic [5:0] reg_en6;
    logic [2:0] mux6;
    logic [2:0] alu6;

    multicycle_ctrl_p #(.NREGS(8), .IW(16), .ALU_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .run(run), .instruction(instruction),
        .done(done8), .busy(busy8), .err(err8), .en_i(en_i8), .en_s(en_s8),
        .en_c(en_c8), .reg_en(reg_en8), .mux_sel(mux8), .alu_sel(alu8)
    );

    multicycle_ctrl_p #(.NREGS(6), .IW(16), .ALU_W(3)) u_dut6 (
        .clk(clk), .reset(reset), .run(run), .instruction(instruction),
        .done(done6), .busy(busy6), .err(err6), .en_i(en_i6), .en_s(en_s6),
        .en_c(en_c6), .reg_en(reg_en6), .mux_sel(mux6), .alu_sel(alu6)
    );

    always #5 clk = ~clk;

    // Packed view {busy,done,err,en_i,en_s,en_c,alu[3],mux[4],reg_en[16]}
    logic [28:0] o8, o6;
    assign o8 = {busy8, done8, err8, en_i8, en_s8, en_c8, alu8, mux8, 8'b0, reg_en8};
    assign o6 = {busy6, done6, err6, en_i6, en_s6, en_c6, alu6, 1'b0, mux6, 10'b0, reg_en6};

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mk(input int rx, input int ry, input int alu, input int op);
        logic [15:0] v;
        v        = '0;
        v[15:13] = rx[2:0];
        v[12:10] = ry[2:0];
        v[4:2]   = alu[2:0];
        v[1:0]   = op[1:0];
        return v;
    endfunction

    function automatic int nregs_of(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic bit is_bad(input int n, input logic [15:0] ins);
        return (int'(ins[15:13]) >= n) || (int'(ins[12:10]) >= n);
    endfunction

    // Number of cycles an instruction keeps the controller busy
    function automatic int ilen(input int n, input logic [15:0] ins);
        if (is_bad(n, ins)) return 2;
        return (ins[1:0] == 2'b10) ? 4 : 2;
    endfunction

    // Expected outputs for cycle k (1 = fetch) of an active instruction
    function automatic logic [28:0] exp_out(input int n, input bit act, input int k,
                                            input logic [15:0] ins);
        bit b, dn, er, ei, es, ec;
        int rx, ry, alu, op, mux, regen;
        b = 0; dn = 0; er = 0; ei = 0; es = 0; ec = 0;
        alu = 0; mux = 0; regen = 0;
        rx = int'(ins[15:13]);
        ry = int'(ins[12:10]);
        op = int'(ins[1:0]);
        if (act) begin
            b = 1;
            if (k == 1) begin
                ei = 1;
            end else if (is_bad(n, ins)) begin
                dn = 1; er = 1;
            end else begin
                case (op)
                    2: begin
                        if (k == 2) begin es = 1; mux = rx; end
                        else if (k == 3) begin ec = 1; mux = ry; alu = int'(ins[4:2]); end
                        else begin regen = 1 << rx; dn = 1; mux = n; end
                    end
                    0: begin regen = 1 << rx; dn = 1; mux = ry; end
                    1: begin
                        dn = 1;
                        if (c_MVI) begin regen = 1 << rx; mux = n + 1; end
                    end
                    default: dn = 1;
                endcase
            end
        end
        return {b, dn, er, ei, es, ec, 3'(alu), 4'(mux), 16'(regen)};
    endfunction

    // Instruction-level model: active flag, cycle index, latched instruction
    bit          m_act[2];
    int          m_k[2];
    logic [15:0] m_ins[2];

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d] <= 1'b0;
                m_k[d]   <= 0;
                m_ins[d] <= '0;
            end else if (!m_act[d]) begin
                if (run) begin
                    m_act[d] <= 1'b1;
                    m_k[d]   <= 1;
                end
            end else if (!run) begin
                m_act[d] <= 1'b0;
            end else begin
                if (m_k[d] == 1) m_ins[d] <= instruction;
                if (m_k[d] >= ilen(nregs_of(d), (m_k[d] == 1) ? instruction : m_ins[d]))
                    m_act[d] <= 1'b0;
                else
                    m_k[d] <= m_k[d] + 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dut8", 32'(o8), 32'(exp_out(8, m_act[0], m_k[0], m_ins[0])));
            check("model_dut6", 32'(o6), 32'(exp_out(6, m_act[1], m_k[1], m_ins[1])));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic go_idle();
        run = 1'b0;
        step();
        step();
    endtask

    initial begin
        step();
        step();
        check("reset_out8", 32'(o8), 32'h0);
        check("reset_out6", 32'(o6), 32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        step();

        // ALU R3 <- R3 op5 R6
        instruction = mk(3, 6, 5, 2);
        run = 1'b1;
        step();
        check("alu_fetch_en_i", 32'(en_i8), 32'h1);
        step();
        check("alu_load_a_en_s", 32'(en_s8), 32'h1);
        check("alu_load_a_mux", 32'(mux8), 32'h3);
        instruction = 16'($urandom);
        step();
        check("alu_load_g_en_c", 32'(en_c8), 32'h1);
        check("alu_load_g_mux", 32'(mux8), 32'h6);
        check("alu_load_g_alu", 32'(alu8), 32'h5);
        step();
        check("alu_wb_reg_en", 32'(reg_en8), 32'h08);
        check("alu_wb_done", 32'(done8), 32'h1);
        check("alu_wb_mux", 32'(mux8), 32'h8);
        go_idle();

        // Asynchronous reset in the middle of LOAD_G
        instruction = mk(2, 4, 1, 2);
        run = 1'b1;
        step();
        step();
        step();
        check("rst_pre_en_c", 32'(en_c8), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst_async_out8", 32'(o8), 32'h0);
        run = 1'b0;
        step();
        reset = 1'b0;

        // MV R1 <- R7 with run held high: back-to-back fetch
        instruction = mk(1, 7, 0, 0);
        run = 1'b1;
        step();
        check("mv_fetch_en_i", 32'(en_i8), 32'h1);
        step();
        check("mv_wb_reg_en", 32'(reg_en8), 32'h02);
        check("mv_wb_mux", 32'(mux8), 32'h7);
        check("mv_wb_done", 32'(done8), 32'h1);
        step();
        check("mv_idle_busy", 32'(busy8), 32'h0);
        step();
        check("mv_refetch_en_i", 32'(en_i8), 32'h1);
        go_idle();

        // run dropped in LOAD_A
        instruction = mk(4, 5, 2, 2);
        run = 1'b1;
        step();
        step();
        check("abort_load_a_en_s", 32'(en_s8), 32'h1);
        run = 1'b0;
        step();
        check("abort_out8", 32'(o8), 32'h0);
        step();

        // rx=7 on the NREGS=6 instance
        instruction = mk(7, 1, 0, 0);
        run = 1'b1;
        step();
        step();
        check("bad_err6", 32'(err6), 32'h1);
        check("bad_done6", 32'(done6), 32'h1);
        check("bad_reg_en6", 32'(reg_en6), 32'h0);
        check("bad_reg_en8", 32'(reg_en8), 32'h80);
        go_idle();

        // op 01: MVI when enabled, NOP otherwise
        instruction = mk(2, 0, 0, 1);
        run = 1'b1;
        step();
        step();
        check("op01_done", 32'(done8), 32'h1);
        check("op01_reg_en", 32'(reg_en8), c_MVI ? 32'h04 : 32'h00);
        check("op01_mux", 32'(mux8), c_MVI ? 32'h9 : 32'h0);
        go_idle();

        // Randomized traffic with occasional run drops and resets
        for (int i = 0; i < 800; i++) begin
            step();
            run         = ($urandom_range(0, 7) != 0);
            instruction = 16'($urandom);
            reset       = ($urandom_range(0, 99) == 0);
        end
        step();
        reset = 1'b0;
        run   = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
